// File: rtl/oci_monitor_access_ctrl_if.sv
// Command, debug-memory and status signals of the monitor access sequencer.
// The slave modport is the sequencer's view; the master modport is the view of its surroundings.
interface oci_monitor_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       cmd_data;
    logic              cmd_autoinc;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_waitrequest;

    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_autoinc, mem_readdata, mem_waitrequest,
        output cmd_ready, mem_addr, mem_read, mem_write, mem_writedata,
               MonDReg, monitor_ready, monitor_error, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_autoinc, mem_readdata, mem_waitrequest,
        input  cmd_ready, mem_addr, mem_read, mem_write, mem_writedata,
               MonDReg, monitor_ready, monitor_error, busy
    );
endinterface

// File: rtl/oci_monitor_access_ctrl.sv
// Sysclk sequencer that runs each debug-host command as one waitrequest-style
// transaction on the debug memory port and reports the result in MonDReg.
module oci_monitor_access_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    oci_monitor_access_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_SET_ADDR = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_WRITE    = 2'b11;

    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dreg_q, dreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              autoinc_q, autoinc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    assign accept = bus.cmd_valid && (state_q == S_IDLE);

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no path infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        dreg_d    = dreg_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rdy_d     = rdy_q;
        err_d     = err_q;
        autoinc_d = autoinc_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_SET_ADDR: begin
                            addr_d = bus.cmd_data[ADDR_W-1:0];
                            err_d  = 1'b0;
                        end
                        OP_READ, OP_WRITE: begin
                            rdy_d     = 1'b0;
                            err_d     = 1'b0;
                            cnt_d     = '0;
                            autoinc_d = bus.cmd_autoinc;
                            if (bus.cmd_op == OP_READ) begin
                                rd_d    = 1'b1;
                                state_d = S_RD;
                            end else begin
                                wr_d    = 1'b1;
                                wdata_d = bus.cmd_data;
                                state_d = S_WR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RD, S_WR: begin
                if (!bus.mem_waitrequest) begin
                    if (state_q == S_RD) dreg_d = bus.mem_readdata;
                    if (autoinc_q) addr_d = addr_q + ADDR_W'(1);
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Stalled too long: abandon the transfer, leave addr and MonDReg untouched.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            dreg_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
            autoinc_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dreg_q    <= dreg_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            autoinc_q <= autoinc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.cmd_ready     = (state_q == S_IDLE);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_read      = rd_q;
    assign bus.mem_write     = wr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.MonDReg       = dreg_q;
    assign bus.monitor_ready = rdy_q;
    assign bus.monitor_error = err_q;
endmodule

// File: tb/tb_oci_monitor_access_ctrl.sv
// Scoreboard bench for oci_monitor_access_ctrl: a command-level model predicts transfers
// and results, a memory responder inserts wait states, and a monitor compares.
module tb_oci_monitor_access_ctrl;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] dreg;
        logic        err;
        logic [7:0]  addr;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    oci_monitor_access_ctrl_if #(.ADDR_W(8)) bus ();

    oci_monitor_access_ctrl #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    xfer_t xfer_q[$];
    res_t  res_q[$];

    logic [31:0] mem [256];
    int          cfg_waits = 0;

    // Command-level reference state
    logic [7:0]  addr_m = 8'h00;
    logic [31:0] dreg_m = 32'h0;
    logic        err_m  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: holds waitrequest for cfg_waits strobe cycles, junk data while stalled.
    int wcnt = 0;
    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (wcnt < cfg_waits) begin
                bus.mem_waitrequest = 1'b1;
                bus.mem_readdata    = $urandom;
                wcnt++;
            end else begin
                bus.mem_waitrequest = 1'b0;
                bus.mem_readdata    = mem[bus.mem_addr];
            end
        end else begin
            wcnt = 0;
            bus.mem_waitrequest = 1'($urandom_range(0, 1));
            bus.mem_readdata    = $urandom;
        end
    end

    // Monitor: samples one time unit before each rising edge.
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_ready = 1'b1;
    logic [7:0]  held_addr;
    logic [31:0] held_wdata;
    xfer_t       mx;
    res_t        mr;
    always @(negedge clk) begin
        #4;
        cyc++;
        if (!reset_n) begin
            prev_strobe = 1'b0;
            prev_ready  = 1'b1;
        end else begin
            check("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'h0);
            if (prev_strobe && (bus.mem_read || bus.mem_write)) begin
                check("addr_stable", 32'(bus.mem_addr), 32'(held_addr));
                check("wdata_stable", bus.mem_writedata, held_wdata);
            end
            if (!prev_strobe && (bus.mem_read || bus.mem_write)) begin
                held_addr  = bus.mem_addr;
                held_wdata = bus.mem_writedata;
            end
            if ((bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) begin
                if (xfer_q.size() == 0) begin
                    check("unexpected_xfer", 32'h1, 32'h0);
                end else begin
                    mx = xfer_q.pop_front();
                    check("xfer_kind", 32'(bus.mem_write), 32'(mx.is_wr));
                    check("xfer_addr", 32'(bus.mem_addr), 32'(mx.addr));
                    if (mx.is_wr) check("xfer_wdata", bus.mem_writedata, mx.wdata);
                end
            end
            if (bus.monitor_ready && !prev_ready) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    mr = res_q.pop_front();
                    check("res_MonDReg", bus.MonDReg, mr.dreg);
                    check("res_error", 32'(bus.monitor_error), 32'(mr.err));
                    check("res_addr", 32'(bus.mem_addr), 32'(mr.addr));
                    check("res_latency", 32'(cyc - acc_cyc), 32'(mr.lat));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && bus.cmd_op[1]) acc_cyc = cyc;
            prev_strobe = bus.mem_read || bus.mem_write;
            prev_ready  = bus.monitor_ready;
        end
    end

    task automatic check_reset_state();
        check("rst_mem_read", 32'(bus.mem_read), 32'h0);
        check("rst_mem_write", 32'(bus.mem_write), 32'h0);
        check("rst_mem_writedata", bus.mem_writedata, 32'h0);
        check("rst_MonDReg", bus.MonDReg, 32'h0);
        check("rst_ready", 32'(bus.monitor_ready), 32'h1);
        check("rst_error", 32'(bus.monitor_error), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
    endtask

    // Issue one command, predict its outcome, and hold cmd_valid with junk while busy.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input logic ai,
                          input int waits);
        xfer_t x;
        res_t  r;
        int    budget;
        @(negedge clk);
        budget = 0;
        while (bus.busy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        case (op)
            2'b01: begin
                addr_m = data[7:0];
                err_m  = 1'b0;
            end
            2'b10, 2'b11: begin
                if (waits < TIMEOUT) begin
                    x.is_wr = op[0];
                    x.addr  = addr_m;
                    x.wdata = data;
                    xfer_q.push_back(x);
                    if (op[0]) mem[addr_m] = data;
                    else       dreg_m = mem[addr_m];
                    if (ai) addr_m = addr_m + 8'd1;
                    err_m = 1'b0;
                    r.lat = waits + 3;
                end else begin
                    err_m = 1'b1;
                    r.lat = TIMEOUT + 2;
                end
                r.dreg = dreg_m;
                r.err  = err_m;
                r.addr = addr_m;
                res_q.push_back(r);
            end
            default: ;
        endcase
        cfg_waits       = waits;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_data    = data;
        bus.cmd_autoinc = ai;
        @(negedge clk);
        if (!op[1]) begin
            bus.cmd_valid = 1'b0;
            check("idle_ready", 32'(bus.monitor_ready), 32'h1);
            check("idle_error", 32'(bus.monitor_error), 32'(err_m));
            check("idle_addr", 32'(bus.mem_addr), 32'(addr_m));
            return;
        end
        check("accept_error_clear", 32'(bus.monitor_error), 32'h0);
        check("accept_ready_low", 32'(bus.monitor_ready), 32'h0);
        budget = 0;
        while (bus.busy && budget < TIMEOUT + 20) begin
            check("busy_cmd_ready", 32'(bus.cmd_ready), 32'h0);
            bus.cmd_op      = 2'($urandom_range(0, 3));
            bus.cmd_data    = $urandom;
            bus.cmd_autoinc = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
        end
        if (bus.busy) check("done_within_bound", 32'h0, 32'h1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          op_r;
        int          w;
        logic [31:0] rst_addr_saved;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_data    = 32'h0;
        bus.cmd_autoinc = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;

        // Write with autoinc, zero waits
        do_cmd(2'b01, 32'h0000_0012, 1'b0, 0);
        do_cmd(2'b11, 32'hDEAD_BEEF, 1'b1, 0);
        check("autoinc_addr_0x13", 32'(bus.mem_addr), 32'h13);

        // Read with 4 wait states
        mem[8'h12] = 32'hCAFE_F00D;
        do_cmd(2'b01, 32'h0000_0012, 1'b0, 0);
        do_cmd(2'b10, 32'h0, 1'b0, 4);
        check("read_MonDReg", bus.MonDReg, 32'hCAFE_F00D);

        // Timeout, sticky error across NOP, cleared by next READ
        do_cmd(2'b10, 32'h0, 1'b1, TIMEOUT);
        do_cmd(2'b00, 32'hFFFF_FFFF, 1'b0, 0);
        do_cmd(2'b10, 32'h0, 1'b0, 0);
        do_cmd(2'b10, 32'h0, 1'b0, TIMEOUT - 1);

        // Address wrap
        do_cmd(2'b01, 32'h0000_00FF, 1'b0, 0);
        do_cmd(2'b10, 32'h0, 1'b1, 0);
        do_cmd(2'b10, 32'h0, 1'b1, 1);
        check("wrap_addr", 32'(bus.mem_addr), 32'h01);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            op_r = $urandom_range(0, 9);
            w    = ($urandom_range(0, 11) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            do_cmd((op_r < 2) ? 2'b01 : (op_r == 2) ? 2'b00 : (op_r < 6) ? 2'b10 : 2'b11,
                   $urandom, 1'($urandom_range(0, 1)), w);
        end

        // Reset during the second wait state of a WRITE
        do_cmd(2'b01, 32'h0000_0055, 1'b0, 0);
        @(negedge clk);
        rst_addr_saved = mem[8'h55];
        cfg_waits       = 10;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 2'b11;
        bus.cmd_data    = 32'h1234_5678;
        bus.cmd_autoinc = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("pre_reset_write_strobe", 32'(bus.mem_write), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_drops_write", 32'(bus.mem_write), 32'h0);
        mem[8'h55] = rst_addr_saved;
        addr_m = 8'h00;
        dreg_m = 32'h0;
        err_m  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_state();
        do_cmd(2'b10, 32'h0, 1'b1, 2);
        do_cmd(2'b00, 32'h0, 1'b0, 0);
        repeat (3) @(negedge clk);

        check("xfer_queue_drained", 32'(xfer_q.size()), 32'h0);
        check("result_queue_drained", 32'(res_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/oci_monitor_access_ctrl.md
Name: oci_monitor_access_ctrl

Overview:
Sysclk-domain sequencer for debug-host accesses to the on-chip debug memory, which holds the monitor RAM and ROM. It accepts decoded debug commands (set address, read, write) from the JTAG command decode over a valid/ready handshake. It runs each command as a single waitrequest-style memory transaction and returns the read data in MonDReg with monitor_ready/monitor_error status. It sits between the debug module's sysclk command decode and the debug memory port.

Parameters:
ADDR_W, 8, word-address width of the debug memory (256 x 32-bit words).
TIMEOUT, 64, maximum number of cycles a transaction may remain stalled by mem_waitrequest before it is aborted; legal range 2..65535.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge
cmd_op  in  2  command: 00 NOP, 01 SET_ADDR, 10 READ, 11 WRITE
cmd_data  in  32  write data for WRITE; address in bits [ADDR_W-1:0] for SET_ADDR
cmd_autoinc  in  1  increment the address after a successful READ or WRITE
mem_addr  out  ADDR_W  memory word address
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_writedata  out  32  write data
mem_readdata  in  32  read data, valid in the cycle mem_read is high and mem_waitrequest is low
mem_waitrequest  in  1  stall for the current transfer
MonDReg  out  32  monitor data register
monitor_ready  out  1  last command complete
monitor_error  out  1  last command timed out
busy  out  1  state is not IDLE

Behaviour:
- Reset values: addr=0, MonDReg=0, monitor_ready=1, monitor_error=0, mem_read=0, mem_write=0, mem_writedata=0, state=IDLE. All outputs are registered except cmd_ready and busy, which are decoded from state.
- States: IDLE, RD, WR, DONE.
- cmd_ready is high only in IDLE. busy is high whenever state is not IDLE.
- IDLE, on accepted NOP: no state change; status bits keep their values.
- IDLE, on accepted SET_ADDR: addr <= cmd_data[ADDR_W-1:0]; monitor_error <= 0; monitor_ready stays 1; state stays IDLE.
- IDLE, on accepted READ: monitor_ready <= 0; monitor_error <= 0; mem_read <= 1; wait counter cleared; go to RD.
- IDLE, on accepted WRITE: same as READ, except mem_write <= 1 and mem_writedata <= cmd_data; go to WR.
- RD or WR with mem_waitrequest=0: the transfer completes in that cycle.
  - RD completion: MonDReg <= mem_readdata.
  - Both: strobe drops to 0; if cmd_autoinc, addr <= addr+1 (modulo 2^ADDR_W, so all-ones wraps to 0); go to DONE.
- RD or WR with mem_waitrequest=1: the wait counter increments.
  - When the counter reaches TIMEOUT-1 while waitrequest is still high: the strobe drops, monitor_error <= 1, addr and MonDReg are unchanged, go to DONE.
- DONE: monitor_ready <= 1; go to IDLE. The next command can be accepted one cycle later.
- Latency, accept edge to monitor_ready=1, with zero wait states: 3 cycles.
  - Edge 1: accept, strobe asserted.
  - Edge 2: transfer completes, go to DONE.
  - Edge 3: monitor_ready <= 1.
  - Each wait state adds 1 cycle. A timeout gives TIMEOUT+2 cycles.
- Address and data stability: mem_addr and mem_writedata stay constant while the strobe is high. mem_read and mem_write are never high together.
- cmd_op, cmd_data and cmd_autoinc are sampled only on the accept edge; changes outside IDLE are ignored.
- monitor_error is sticky until the next accepted SET_ADDR, READ or WRITE.
- Asynchronous reset mid-transaction: strobes drop immediately and all reset values apply. No partial MonDReg update occurs.
- A readdata value presented while waitrequest is high is never captured.

Test Plan:
- SET_ADDR cmd_data=0x0000_0012, then WRITE 0xDEADBEEF with autoinc=1, zero waits -> mem_write pulse at addr 0x12 with data 0xDEADBEEF; addr becomes 0x13; monitor_ready returns to 1 exactly 3 cycles after accept.
- SET_ADDR 0x12, READ with mem_readdata=0xCAFEF00D and 4 wait states -> MonDReg=0xCAFEF00D; mem_addr held at 0x12 for all 5 strobe cycles; accept-to-ready is 7 cycles.
- mem_waitrequest held high, TIMEOUT=64, READ -> strobe drops after 64 strobe cycles; monitor_error=1; MonDReg and addr unchanged; next READ clears monitor_error on its accept edge.
- SET_ADDR 0xFF, two READs with autoinc=1 -> reads hit addresses 0xFF then 0x00 (wrap).
- cmd_valid held high while busy, with cmd_op and cmd_data toggling -> cmd_ready=0; no extra transactions; only the first command executes.
- reset_n asserted during the 2nd wait state of a WRITE -> mem_write=0 immediately; after release addr=0, MonDReg=0, monitor_ready=1, monitor_error=0, cmd_ready=1.
